systolic_frame_hs: RTL and testbench

SYSTOLIC_FRAME_HS -- requirements
Module: systolic_frame_hs

---
 rtl/systolic_frame_hs.sv | 202 ++++++++++++++++++++
 tb/tb_systolic_frame_hs.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_frame_hs.sv
// Weight-stationary NxN systolic matrix multiplier with valid/ready row handshakes.
// Loads W (optionally reused), buffers D, runs the skewed PE grid and streams R = D*W out.
module systolic_frame_mac #(
  parameter int DATA_SIZE = 16,
  parameter int ACC_SIZE  = 40
) (
  input  logic signed [DATA_SIZE-1:0] i_a,
  input  logic signed [DATA_SIZE-1:0] i_w,
  input  logic signed [ACC_SIZE-1:0]  i_psum,
  output logic signed [ACC_SIZE-1:0]  o_psum
);
  logic signed [2*DATA_SIZE-1:0] w_prod;

  assign w_prod = i_a * i_w;
  assign o_psum = i_psum + ACC_SIZE'(w_prod);
endmodule

module systolic_frame_hs #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 16,
  parameter int ACC_SIZE    = 40
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            reuse_weights,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] w_row,
  input  logic                            d_valid,
  output logic                            d_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] d_row,
  output logic                            r_valid,
  input  logic                            r_ready,
  output logic [MATRIX_SIZE*ACC_SIZE-1:0]  r_row,
  output logic                            busy,
  output logic                            frame_done
);
  localparam int N   = MATRIX_SIZE;
  localparam int DW  = DATA_SIZE;
  localparam int AW  = ACC_SIZE;
  localparam int IW  = $clog2(N);
  localparam int CCW = $clog2(3*N-2);
  localparam logic [IW-1:0]  LAST_I = IW'(N-1);
  localparam logic [CCW-1:0] LAST_C = CCW'(3*N-3);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_COMPUTE, S_OUTPUT} state_t;

  state_t r_state, w_nxt;
  logic [IW-1:0]  r_w_cnt, r_d_cnt, r_o_cnt;
  logic [CCW-1:0] r_c_cnt;
  logic           r_wl;

  logic [N-1:0][N-1:0][DW-1:0] r_wbuf, r_dbuf;
  logic [N-1:0][N-1:0][AW-1:0] r_obuf;
  logic [N-1:0][N-2:0][DW-1:0] r_a;
  logic [N-2:0][N-1:0][AW-1:0] r_p;

  logic [N-1:0][N-1:0][DW-1:0] w_ain;
  logic [N-1:0][N-1:0][AW-1:0] w_pin, w_pn;
  logic [N-1:0][DW-1:0]        w_feed;
  logic [N-1:0][IW-1:0]        w_oidx;
  logic [N-1:0]                w_cap;

  logic w_xfer, d_xfer, r_xfer;

  assign w_xfer = w_valid & w_ready;
  assign d_xfer = d_valid & d_ready;
  assign r_xfer = r_valid & r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_ready    = 1'b0;
    d_ready    = 1'b0;
    r_valid    = 1'b0;
    frame_done = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_nxt = (reuse_weights && r_wl) ? S_STREAM : S_LOAD_W;
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && r_w_cnt == LAST_I) w_nxt = S_STREAM;
      end
      S_STREAM: begin
        d_ready = 1'b1;
        if (d_valid && r_d_cnt == LAST_I) w_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (r_c_cnt == LAST_C) w_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        r_valid = 1'b1;
        if (r_ready && r_o_cnt == LAST_I) begin
          frame_done = 1'b1;
          w_nxt      = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_cnt <= '0;
      r_d_cnt <= '0;
      r_o_cnt <= '0;
      r_c_cnt <= '0;
      r_wl    <= 1'b0;
      r_wbuf  <= '0;
      r_dbuf  <= '0;
    end else begin
      case (r_state)
        S_LOAD_W: if (w_xfer) begin
          r_wbuf[r_w_cnt] <= w_row;
          if (r_w_cnt == LAST_I) begin
            r_w_cnt <= '0;
            r_wl    <= 1'b1;
          end else begin
            r_w_cnt <= r_w_cnt + 1'b1;
          end
        end
        S_STREAM: if (d_xfer) begin
          r_dbuf[r_d_cnt] <= d_row;
          r_d_cnt         <= (r_d_cnt == LAST_I) ? '0 : r_d_cnt + 1'b1;
        end
        S_COMPUTE: r_c_cnt <= (r_c_cnt == LAST_C) ? '0 : r_c_cnt + 1'b1;
        S_OUTPUT: if (r_xfer) r_o_cnt <= (r_o_cnt == LAST_I) ? '0 : r_o_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Row k sees D[c-k][k] at compute cycle c; the wrapped difference is >= N outside the window.
  for (genvar k = 0; k < N; k++) begin : g_feed
    logic [CCW-1:0] w_fdiff;
    assign w_fdiff   = r_c_cnt - CCW'(k);
    assign w_feed[k] = (w_fdiff < CCW'(N)) ? r_dbuf[w_fdiff[IW-1:0]][k] : '0;
  end

  // Column j of the bottom row yields R[c-(N-1)-j][j] as the sum being registered.
  for (genvar j = 0; j < N; j++) begin : g_cap
    logic [CCW-1:0] w_cdiff;
    assign w_cdiff   = r_c_cnt - CCW'(N-1+j);
    assign w_cap[j]  = (r_state == S_COMPUTE) && (w_cdiff < CCW'(N));
    assign w_oidx[j] = w_cdiff[IW-1:0];
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a0
        assign w_ain[k][j] = w_feed[k];
      end else begin : g_an
        assign w_ain[k][j] = r_a[k][j-1];
      end
      if (k == 0) begin : g_p0
        assign w_pin[k][j] = '0;
      end else begin : g_pn
        assign w_pin[k][j] = r_p[k-1][j];
      end
      systolic_frame_mac #(.DATA_SIZE(DW), .ACC_SIZE(AW)) u_mac (
        .i_a    (w_ain[k][j]),
        .i_w    (r_wbuf[k][j]),
        .i_psum (w_pin[k][j]),
        .o_psum (w_pn[k][j])
      );
    end
  end

  // Grid pipeline is flushed to zero whenever no frame is computing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_p <= '0;
    end else if (r_state != S_COMPUTE) begin
      r_a <= '0;
      r_p <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N-1; j++) r_a[k][j] <= w_ain[k][j];
      for (int k = 0; k < N-1; k++)
        for (int j = 0; j < N; j++) r_p[k][j] <= w_pn[k][j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_obuf <= '0;
    end else begin
      for (int j = 0; j < N; j++)
        if (w_cap[j]) r_obuf[w_oidx[j]][j] <= w_pn[N-1][j];
    end
  end

  assign r_row = r_valid ? r_obuf[r_o_cnt] : '0;
endmodule

// File: tb/tb_systolic_frame_hs.sv
// Directed bench for systolic_frame_hs at N=2, 8-bit data, 16-bit results.
module tb_systolic_frame_hs;
  logic        clk = 1'b0;
  logic        reset, start, reuse_weights;
  logic        w_valid, d_valid, r_ready;
  logic [15:0] w_row, d_row;
  logic        w_ready, d_ready, r_valid, busy, frame_done;
  logic [31:0] r_row;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, fd_cnt = 0, wr_cnt = 0;

  systolic_frame_hs #(.MATRIX_SIZE(2), .DATA_SIZE(8), .ACC_SIZE(16)) dut (
    .clk(clk), .reset(reset), .start(start), .reuse_weights(reuse_weights),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .d_valid(d_valid), .d_ready(d_ready), .d_row(d_row),
    .r_valid(r_valid), .r_ready(r_ready), .r_row(r_row),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (w_ready)    wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pk(input int a, input int b);
    return {8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] rk(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  task automatic do_start(input logic reuse);
    start = 1'b1; reuse_weights = reuse;
    step();
    start = 1'b0; reuse_weights = 1'b0;
  endtask

  task automatic xfer_w(input logic [15:0] row);
    int t = 0;
    w_valid = 1'b1; w_row = row;
    while (!w_ready && t < 20) begin step(); t++; end
    if (t >= 20) chk("w_timeout", 0, 1);
    step();
    w_valid = 1'b0;
  endtask

  task automatic xfer_d(input logic [15:0] row);
    int t = 0;
    d_valid = 1'b1; d_row = row;
    while (!d_ready && t < 20) begin step(); t++; end
    if (t >= 20) chk("d_timeout", 0, 1);
    step();
    d_valid = 1'b0;
  endtask

  task automatic get_r(output logic [31:0] row, output logic fd);
    int t = 0;
    r_ready = 1'b1;
    while (!r_valid && t < 40) begin step(); t++; end
    if (t >= 40) chk("r_timeout", 0, 1);
    row = r_row; fd = frame_done;
    step();
  endtask

  logic [31:0] row, held;
  logic        fd;
  int          c0, fd0, wr0, t;

  initial begin
    reset = 1'b1; start = 1'b0; reuse_weights = 1'b0;
    w_valid = 1'b0; d_valid = 1'b0; r_ready = 1'b0;
    w_row = '0; d_row = '0;
    step(); step();
    chk("rst_outs", {w_ready, d_ready, r_valid, busy, frame_done}, 5'b0);
    chk("rst_rrow", r_row, 32'h0);

    reset = 1'b0; w_valid = 1'b1; w_row = pk(9, 9);
    step(); step(); step();
    chk("no_xfer_pre_start", {w_ready, busy}, 2'b00);
    w_valid = 1'b0;

    // basic frame with latency
    c0 = cyc; fd0 = fd_cnt;
    do_start(1'b0);
    chk("load_w_state", {busy, w_ready, d_ready}, 3'b110);
    xfer_w(pk(1, 2)); xfer_w(pk(3, 4));
    chk("stream_state", {w_ready, d_ready}, 2'b01);
    xfer_d(pk(5, 6)); xfer_d(pk(7, 8));
    chk("compute_state", {busy, w_ready, d_ready, r_valid}, 4'b1000);
    get_r(row, fd); chk("basic_r0", row, rk(23, 34)); chk("basic_fd0", fd, 0);
    get_r(row, fd); chk("basic_r1", row, rk(31, 46)); chk("basic_fd1", fd, 1);
    chk("basic_latency", cyc - c0, 11);
    chk("basic_idle", busy, 0);
    chk("basic_fd_once", fd_cnt - fd0, 1);

    // weight reuse with identity data
    wr0 = wr_cnt;
    do_start(1'b1);
    chk("reuse_state", {w_ready, d_ready}, 2'b01);
    xfer_d(pk(1, 0)); xfer_d(pk(0, 1));
    get_r(row, fd); chk("reuse_r0", row, rk(1, 2));
    get_r(row, fd); chk("reuse_r1", row, rk(3, 4));
    chk("reuse_no_wready", wr_cnt - wr0, 0);

    // signed products and modulo wrap
    do_start(1'b0);
    xfer_w(pk(-128, 0)); xfer_w(pk(-128, 0));
    xfer_d(pk(-128, -128)); xfer_d(pk(-1, 0));
    get_r(row, fd); chk("wrap_r0", row, rk(32768, 0));
    get_r(row, fd); chk("wrap_r1", row, rk(128, 0));

    // input gaps then output backpressure
    r_ready = 1'b0;
    do_start(1'b0);
    xfer_w(pk(1, 2)); xfer_w(pk(3, 4));
    d_valid = 1'b1; d_row = pk(5, 6); step();
    d_valid = 1'b0; d_row = pk(100, 100); step();
    chk("gap_hold1", d_ready, 1);
    step();
    chk("gap_hold2", d_ready, 1);
    d_valid = 1'b1; d_row = pk(7, 8); step();
    d_valid = 1'b0;
    chk("gap_to_compute", {d_ready, busy}, 2'b01);
    t = 0;
    while (!r_valid && t < 40) begin step(); t++; end
    if (t >= 40) chk("bp_timeout", 0, 1);
    held = r_row;
    chk("bp_r0", held, rk(23, 34));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", {r_valid, r_row}, {1'b1, held});
    end
    r_ready = 1'b1; step();
    chk("bp_r1", {r_valid, r_row}, {1'b1, rk(31, 46)});
    step();
    chk("bp_idle", busy, 0);

    // reset in the second compute cycle
    do_start(1'b0);
    xfer_w(pk(1, 2)); xfer_w(pk(3, 4));
    xfer_d(pk(5, 6)); xfer_d(pk(7, 8));
    step();
    reset = 1'b1; #1;
    chk("midrst_outs", {w_ready, d_ready, r_valid, busy, frame_done}, 5'b0);
    chk("midrst_rrow", r_row, 32'h0);
    step();
    reset = 1'b0;
    do_start(1'b1);
    chk("midrst_reload", {w_ready, d_ready}, 2'b10);
    xfer_w(pk(1, 2)); xfer_w(pk(3, 4));
    xfer_d(pk(5, 6)); xfer_d(pk(7, 8));
    get_r(row, fd); chk("midrst_r0", row, rk(23, 34));
    get_r(row, fd); chk("midrst_r1", row, rk(31, 46));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
